// File: rtl/switch_debouncer_pkg.sv
// Board-level constants shared by the switch input path.
// The default debounce length is derived from the board clock and a debounce time in ms.
package switch_debouncer_pkg;

  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 10;

  function automatic int cycles_for_ms(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  localparam int DEFAULT_DEBOUNCE_CYCLES = cycles_for_ms(CLK_HZ, DEBOUNCE_MS);

endpackage

// File: rtl/switch_debouncer_debounce_bit.sv
// One switch bit: two-flop synchroniser, persistence counter, debounced level and edge strobes.
// accept is the combinational "level will be taken this edge" flag, used by the top to register changed.
module debounce_bit
  import switch_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  assign accept = (s2 != stable) && (cnt == CNT_LAST);

  // The counter only advances while the synchronised input disagrees with the
  // accepted level, so any agreeing sample throws away a partial count.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      s1   <= sw;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= s2;
          cnt    <= '0;
          rise   <= s2;
          fall   <= ~s2;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces a bank of slide switches bit by bit and reports clean levels plus edge strobes.
// led mirrors the debounced state so the board shows exactly what downstream logic sees.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH           = 6,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] switch,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic [WIDTH-1:0] led
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] accept;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk   (clk),
      .rst   (rst),
      .sw    (switch[i]),
      .stable(stable[i]),
      .rise  (rise[i]),
      .fall  (fall[i]),
      .accept(accept[i])
    );
  end

  // Registered from the same accept condition as the per-bit strobes so it lands in their cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      changed <= 1'b0;
    end else begin
      changed <= |accept;
    end
  end

  assign led = stable;

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer with a short debounce window.
// The reference model accepts a level once the two-edge-delayed input has disagreed for a full window.
module tb_switch_debouncer;

  localparam int WIDTH = 6;
  localparam int DC    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] switch;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;
  logic [WIDTH-1:0] led;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] hist [0:DC+1];
  logic [WIDTH-1:0] m_stable  = '0;
  logic [WIDTH-1:0] m_rise    = '0;
  logic [WIDTH-1:0] m_fall    = '0;
  logic             m_changed = 1'b0;

  switch_debouncer #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .switch (switch),
    .stable (stable),
    .rise   (rise),
    .fall   (fall),
    .changed(changed),
    .led    (led)
  );

  always #5 clk = ~clk;

  // hist[0] is the raw sample of the previous edge, so the synchronised value seen at
  // this edge is hist[1]; a level is accepted when hist[1..DC] all disagree with it.
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= DC + 1; k++) hist[k] = '0;
      m_stable  = '0;
      m_rise    = '0;
      m_fall    = '0;
      m_changed = 1'b0;
    end else begin
      m_rise = '0;
      m_fall = '0;
      for (int b = 0; b < WIDTH; b++) begin
        logic differs;
        differs = 1'b1;
        for (int k = 1; k <= DC; k++)
          if (hist[k][b] == m_stable[b]) differs = 1'b0;
        if (differs) begin
          m_rise[b]   = ~m_stable[b];
          m_fall[b]   = m_stable[b];
          m_stable[b] = ~m_stable[b];
        end
      end
      m_changed = |(m_rise | m_fall);
      for (int k = DC + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = switch;
    end
  end

  task automatic test_reset();
    rst    = 1'b1;
    switch = 6'h3F;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if ({stable, led, rise, fall, changed} !== 25'd0) begin
        failures++;
        $display("[TB] FAIL reset cycle=%0d got stable=%h led=%h rise=%h fall=%h changed=%b expected all 0",
                 k, stable, led, rise, fall, changed);
      end
    end
    switch = 6'h00;
    rst    = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (stable !== 6'h00 || changed !== 1'b0) begin
        failures++;
        $display("[TB] FAIL post_reset cycle=%0d got stable=%h changed=%b expected 00/0", k, stable, changed);
      end
    end
  endtask

  task automatic test_clean_rise();
    switch = 6'h01;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (stable !== ((k >= 6) ? 6'h01 : 6'h00) || led !== stable ||
          rise !== ((k == 6) ? 6'h01 : 6'h00) || fall !== 6'h00 || changed !== (k == 6)) begin
        failures++;
        $display("[TB] FAIL clean_rise edge=%0d got stable=%h led=%h rise=%h fall=%h changed=%b expected stable=%h rise=%h changed=%b",
                 k, stable, led, rise, fall, changed, (k >= 6) ? 6'h01 : 6'h00, (k == 6) ? 6'h01 : 6'h00, (k == 6));
      end
    end
  endtask

  task automatic test_glitch();
    switch = 6'h05;
    for (int k = 1; k <= 14; k++) begin
      if (k == 4) switch = 6'h01;
      @(negedge clk);
      checks++;
      if (stable !== 6'h01 || rise !== 6'h00 || fall !== 6'h00 || changed !== 1'b0) begin
        failures++;
        $display("[TB] FAIL glitch cycle=%0d got stable=%h rise=%h fall=%h changed=%b expected 01/00/00/0",
                 k, stable, rise, fall, changed);
      end
    end
  endtask

  task automatic test_simultaneous();
    switch = 6'h22;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checks++;
      if (stable !== ((k >= 6) ? 6'h22 : 6'h01) || rise !== ((k == 6) ? 6'h22 : 6'h00) ||
          fall !== ((k == 6) ? 6'h01 : 6'h00) || changed !== (k == 6)) begin
        failures++;
        $display("[TB] FAIL simultaneous edge=%0d got stable=%h rise=%h fall=%h changed=%b", k, stable, rise, fall, changed);
      end
    end
  endtask

  task automatic test_bounce();
    int rise_count;
    int rise_at;
    rise_count = 0;
    rise_at    = -1;
    switch = 6'h02;
    repeat (10) @(negedge clk);
    checks++;
    if (stable !== 6'h02) begin
      failures++;
      $display("[TB] FAIL bounce_setup got stable=%h expected 02", stable);
    end
    // Bit 5 pattern 1,1,0,0,1,1,0,0,1,1 then held high; last toggle lands in cycle 8.
    for (int c = 0; c < 30; c++) begin
      switch = (c < 10 && ((c / 2) % 2) == 1) ? 6'h02 : 6'h22;
      @(negedge clk);
      checks++;
      if ({stable, rise, fall, changed} !== {m_stable, m_rise, m_fall, m_changed}) begin
        failures++;
        $display("[TB] FAIL bounce_model c=%0d got stable=%h rise=%h fall=%h changed=%b expected %h/%h/%h/%b",
                 c, stable, rise, fall, changed, m_stable, m_rise, m_fall, m_changed);
      end
      if (rise !== 6'h00) begin
        rise_count++;
        rise_at = c;
        checks++;
        if (rise !== 6'h20) begin
          failures++;
          $display("[TB] FAIL bounce_rise_value got %h expected 20", rise);
        end
      end
    end
    checks++;
    if (rise_count != 1 || rise_at != 13) begin
      failures++;
      $display("[TB] FAIL bounce_single_rise got count=%0d at=%0d expected count=1 at=13", rise_count, rise_at);
    end
  endtask

  task automatic test_reset_mid_and_sweep();
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] prev;
    int pulses;
    switch = 6'h3F;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (stable !== 6'h00 || rise !== 6'h00 || changed !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset got stable=%h rise=%h changed=%b expected 00/00/0", stable, rise, changed);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (stable !== ((k >= 6) ? 6'h3F : 6'h00) || rise !== ((k == 6) ? 6'h3F : 6'h00) || changed !== (k == 6)) begin
        failures++;
        $display("[TB] FAIL after_mid_reset edge=%0d got stable=%h rise=%h changed=%b", k, stable, rise, changed);
      end
    end
    v = 6'h3F;
    for (int s = 0; s < 6; s++) begin
      prev   = v;
      v      = v + 6'd1;
      switch = v;
      pulses = 0;
      for (int k = 1; k <= 100; k++) begin
        @(negedge clk);
        if (changed === 1'b1) pulses++;
        if (k <= 8) begin
          checks++;
          if (stable !== ((k >= 6) ? v : prev)) begin
            failures++;
            $display("[TB] FAIL sweep step=%0d edge=%0d got stable=%h expected %h", s, k, stable, (k >= 6) ? v : prev);
          end
        end
      end
      checks++;
      if (pulses != 1) begin
        failures++;
        $display("[TB] FAIL sweep_changed step=%0d got pulses=%0d expected 1", s, pulses);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 120; seg++) begin
      switch = WIDTH'($urandom);
      rst    = ($urandom_range(0, 24) == 0);
      hold   = $urandom_range(1, 8);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({stable, rise, fall, changed, led} !== {m_stable, m_rise, m_fall, m_changed, m_stable}) begin
          failures++;
          $display("[TB] FAIL random seg=%0d got stable=%h rise=%h fall=%h changed=%b led=%h expected %h/%h/%h/%b",
                   seg, stable, rise, fall, changed, led, m_stable, m_rise, m_fall, m_changed);
        end
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    switch = 6'h3F;
    for (int k = 0; k <= DC + 1; k++) hist[k] = '0;
    test_reset();
    test_clean_rise();
    test_glitch();
    test_simultaneous();
    test_bounce();
    test_reset_mid_and_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
